// File: rtl/riscv_core_icache_pkg.sv
// riscv_core_icache_pkg: refill FSM states and AXI encodings shared by the icache refill path
package riscv_core_icache_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} refill_state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/riscv_core_icache_axi_refill.sv
// riscv_core_icache_axi_refill: fetches one icache block with a single AXI4 INCR read burst
// Ports: i_mem_req/i_addr request from icache, o_mem_done/o_block/o_bus_err result,
//        o_ar* read-address channel (constant len/size/burst), i_r*/o_rready read-data channel.
module riscv_core_icache_axi_refill
  import riscv_core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 256,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [BLOCK_WIDTH-1:0]    o_block,
  output logic                      o_bus_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);
  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);
  refill_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic full;
  logic accept;
  logic r_hs;
  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst = BURST_INCR;
  assign accept    = (state == ST_IDLE) && i_mem_req;
  assign r_hs      = (state == ST_R) && i_rvalid;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt  = state;
    o_arvalid  = state == ST_AR;
    o_rready   = state == ST_R;
    o_mem_done = state == ST_DONE;
    unique case (state)
      ST_IDLE: state_nxt = i_mem_req ? ST_AR : ST_IDLE;
      ST_AR:   state_nxt = i_arready ? ST_R : ST_AR;
      ST_R:    state_nxt = (i_rvalid && i_rlast) ? ST_DONE : ST_R;
      default: state_nxt = ST_IDLE;
    endcase
  end
  // full marks that the top slot has been written, so surplus beats cannot overwrite it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_araddr  <= '0;
      o_block   <= '0;
      o_bus_err <= 1'b0;
      cnt       <= '0;
      full      <= 1'b0;
    end else if (accept) begin
      o_araddr  <= i_addr & ~OFF_MASK;
      o_bus_err <= 1'b0;
      cnt       <= '0;
      full      <= 1'b0;
    end else if (r_hs) begin
      if (!full) o_block[cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
      full <= full || (cnt == LAST);
      cnt  <= (cnt == LAST) ? cnt : cnt + 1'b1;
      if (i_rresp != RESP_OKAY || (i_rlast && cnt != LAST)) o_bus_err <= 1'b1;
    end
endmodule
